// File: rtl/bp_profiler_sampler.sv
// Run-control and readout sequencer for the core stall/event counter bank.
// Clears and enables the bank, snapshots all counters into a shadow register
// (periodically or on stop) and streams the snapshot one word per handshake.
module bp_profiler_sampler #(
    parameter int unsigned width_p          = 32,
    parameter int unsigned els_p            = 56,
    parameter int unsigned interval_width_p = 32,
    parameter int unsigned seq_width_p      = 16
) (
    input  logic                        clk_i,
    input  logic                        aresetn_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic [interval_width_p-1:0] interval_i,
    input  logic [els_p*width_p-1:0]    counters_i,
    output logic                        en_o,
    output logic                        clear_o,
    output logic                        v_o,
    input  logic                        ready_i,
    output logic [width_p-1:0]          data_o,
    output logic [$clog2(els_p)-1:0]    idx_o,
    output logic                        last_o,
    output logic [seq_width_p-1:0]      seq_o,
    output logic                        busy_o,
    output logic                        overrun_o
);

    localparam int unsigned idx_width_lp = $clog2(els_p);
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(els_p - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StFinal = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic [interval_width_p-1:0] interval_q, interval_d;
    logic [interval_width_p-1:0] icnt_q, icnt_d;
    logic [idx_width_lp-1:0]     idx_q, idx_d;
    logic [seq_width_p-1:0]      seq_q, seq_d;
    logic                        overrun_q, overrun_d;
    logic                        stop_pending_q, stop_pending_d;
    logic [width_p-1:0]          shadow_q [els_p];

    logic capture;
    logic expire;
    logic hs;
    logic last_hs;

    // Streaming and bank-control outputs decoded from the registered state
    always_comb begin
        v_o       = (state_q == StDrain) || (state_q == StFinal);
        clear_o   = (state_q == StClear);
        // A pending stop freezes the bank while the current snapshot drains
        en_o      = (state_q == StRun) || ((state_q == StDrain) && !stop_pending_q);
        busy_o    = (state_q != StIdle);
        data_o    = v_o ? shadow_q[idx_q] : '0;
        idx_o     = idx_q;
        last_o    = v_o && (idx_q == last_idx_lp);
        seq_o     = seq_q;
        overrun_o = overrun_q;
    end

    // Next-state logic for the run/readout sequencer
    always_comb begin
        state_d        = state_q;
        interval_d     = interval_q;
        icnt_d         = icnt_q;
        idx_d          = idx_q;
        seq_d          = seq_q;
        overrun_d      = overrun_q;
        stop_pending_d = stop_pending_q;
        capture        = 1'b0;

        expire  = (interval_q != '0) && (icnt_q == interval_q - interval_width_p'(1));
        hs      = v_o && ready_i;
        last_hs = hs && (idx_q == last_idx_lp);

        // Word index advances on every handshake; a completed snapshot bumps seq
        if (hs) begin
            if (idx_q == last_idx_lp) begin
                idx_d = '0;
                seq_d = seq_q + seq_width_p'(1);
            end else begin
                idx_d = idx_q + idx_width_lp'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d        = StClear;
                    interval_d     = interval_i;
                    icnt_d         = '0;
                    idx_d          = '0;
                    seq_d          = '0;
                    overrun_d      = 1'b0;
                    stop_pending_d = 1'b0;
                end
            end
            StClear: begin
                state_d = StRun;
                icnt_d  = '0;
            end
            StRun: begin
                // Stop outranks a coincident interval expiry: single final snapshot
                if (stop_i) begin
                    capture = 1'b1;
                    state_d = StFinal;
                end else if (expire) begin
                    capture = 1'b1;
                    icnt_d  = '0;
                    state_d = StDrain;
                end else begin
                    icnt_d = icnt_q + interval_width_p'(1);
                end
            end
            StDrain: begin
                // Interval keeps ticking while draining; an expiry here is a dropped sample
                if (!stop_pending_q) begin
                    if (expire) begin
                        overrun_d = 1'b1;
                        icnt_d    = '0;
                    end else begin
                        icnt_d = icnt_q + interval_width_p'(1);
                    end
                end
                if (stop_i) begin
                    stop_pending_d = 1'b1;
                end
                if (last_hs) begin
                    if (stop_pending_q || stop_i) begin
                        capture = 1'b1;
                        state_d = StFinal;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StFinal: begin
                if (last_hs) begin
                    state_d        = StIdle;
                    stop_pending_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q        <= StIdle;
            interval_q     <= '0;
            icnt_q         <= '0;
            idx_q          <= '0;
            seq_q          <= '0;
            overrun_q      <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            interval_q     <= interval_d;
            icnt_q         <= icnt_d;
            idx_q          <= idx_d;
            seq_q          <= seq_d;
            overrun_q      <= overrun_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    // Shadow snapshot of the live counters; only read while v_o is high
    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int k = 0; k < int'(els_p); k++) begin
                shadow_q[k] <= counters_i[k*width_p +: width_p];
            end
        end
    end

endmodule

// File: tb/tb_bp_profiler_sampler.sv
// Directed bench for bp_profiler_sampler. The counter bank is modelled as a
// free-running generation count: word k = {gen, k}, gen bumps every falling edge.
module tb_bp_profiler_sampler;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 56;
    localparam int unsigned IW = 32;
    localparam int unsigned SW = 16;

    logic          clk_i = 1'b0;
    logic          aresetn_i;
    logic          start_i;
    logic          stop_i;
    logic [IW-1:0] interval_i;
    logic [N*W-1:0] counters_i;
    logic          en_o;
    logic          clear_o;
    logic          v_o;
    logic          ready_i;
    logic [W-1:0]  data_o;
    logic [5:0]    idx_o;
    logic          last_o;
    logic [SW-1:0] seq_o;
    logic          busy_o;
    logic          overrun_o;

    logic [23:0]   gen = '0;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) gen <= gen + 24'd1;

    for (genvar k = 0; k < N; k++) begin : g_cnt
        assign counters_i[k*W +: W] = {gen, 8'(k)};
    end

    bp_profiler_sampler #(
        .width_p         (W),
        .els_p           (N),
        .interval_width_p(IW),
        .seq_width_p     (SW)
    ) dut (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .interval_i(interval_i),
        .counters_i(counters_i),
        .en_o      (en_o),
        .clear_o   (clear_o),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .idx_o     (idx_o),
        .last_o    (last_o),
        .seq_o     (seq_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start pulse, then one CLEAR cycle, leaving the DUT in its first RUN cycle
    task automatic start_run(input logic [IW-1:0] iv, input string tag);
        interval_i = iv;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        check_eq({tag, "_clear"}, clear_o, 1);
        check_eq({tag, "_clr_en"}, en_o, 0);
        check_eq({tag, "_busy"}, busy_o, 1);
        tick();
        check_eq({tag, "_clear_off"}, clear_o, 0);
        check_eq({tag, "_run_en"}, en_o, 1);
        check_eq({tag, "_seq0"}, seq_o, 0);
    endtask

    // Count cycles until v_o rises; cap is the gen value the capture edge saw
    task automatic wait_v(input int exp_ticks, input string tag, output logic [23:0] cap);
        int n;
        logic [23:0] g;
        n = 0;
        g = gen;
        do begin
            g = gen;
            tick();
            n++;
        end while (!v_o && n < 1000);
        check_eq({tag, "_lat"}, n, exp_ticks);
        cap = g + 24'd1;
    endtask

    task automatic stop_pulse(output logic [23:0] cap);
        logic [23:0] g;
        g      = gen;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        cap    = g + 24'd1;
    endtask

    // Stream one snapshot. mode 0: ready always; mode 1: ready 1-of-3 cycles.
    // stop_at >= 0 raises stop_i alongside that handshake.
    task automatic drain(input int mode, input int stop_at, input logic [SW-1:0] eseq,
                         input logic [23:0] egen, input string tag, output logic [23:0] last_gen);
        int hs;
        int cyc;
        logic [23:0] g;
        hs  = 0;
        cyc = 0;
        g   = gen;
        while (hs < N && cyc < 1000) begin
            ready_i = (mode == 0) || (cyc % 3 == 2);
            stop_i  = (hs == stop_at);
            check_eq($sformatf("%s_v%0d", tag, cyc), v_o, 1);
            check_eq($sformatf("%s_idx%0d", tag, cyc), idx_o, hs);
            check_eq($sformatf("%s_data%0d", tag, cyc), data_o, {egen, 8'(hs)});
            check_eq($sformatf("%s_last%0d", tag, cyc), last_o, (hs == N - 1));
            check_eq($sformatf("%s_seq%0d", tag, cyc), seq_o, eseq);
            g = gen;
            if (ready_i) hs++;
            tick();
            cyc++;
            stop_i = 1'b0;
        end
        ready_i = 1'b1;
        check_eq({tag, "_cycles"}, cyc, (mode == 0) ? N : 3 * N);
        last_gen = g + 24'd1;
    endtask

    initial begin
        logic [23:0] cap;
        logic [23:0] lg;
        int vcnt;

        aresetn_i  = 1'b0;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        ready_i    = 1'b1;
        interval_i = '0;
        #23;
        check_eq("rst_en", en_o, 0);
        check_eq("rst_clear", clear_o, 0);
        check_eq("rst_v", v_o, 0);
        check_eq("rst_last", last_o, 0);
        check_eq("rst_ovr", overrun_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_idx", idx_o, 0);
        check_eq("rst_seq", seq_o, 0);
        check_eq("rst_data", data_o, 0);
        @(negedge clk_i);
        aresetn_i = 1'b1;
        tick();

        // start and stop together in IDLE: stop wins
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check_eq("ss_busy", busy_o, 0);
        check_eq("ss_clear", clear_o, 0);

        // Periodic snapshot, interval 100, ready always high
        start_run(100, "t1");
        wait_v(100, "t1_first", cap);
        drain(0, -1, 0, cap, "t1_s0", lg);
        check_eq("t1_v_after", v_o, 0);
        check_eq("t1_seq1", seq_o, 1);
        check_eq("t1_en_run", en_o, 1);
        stop_pulse(cap);
        check_eq("t1_en_stop", en_o, 0);
        drain(0, -1, 1, cap, "t1_fin", lg);
        check_eq("t1_idle", busy_o, 0);
        check_eq("t1_seq2", seq_o, 2);

        // Back-pressure: ready 1-of-3 cycles
        start_run(100, "t2");
        wait_v(100, "t2_first", cap);
        drain(1, -1, 0, cap, "t2_s0", lg);
        stop_pulse(cap);
        drain(0, -1, 1, cap, "t2_fin", lg);
        check_eq("t2_idle", busy_o, 0);

        // Interval 20: expiries during drain are dropped and flagged
        start_run(20, "t3");
        wait_v(20, "t3_first", cap);
        check_eq("t3_ovr0", overrun_o, 0);
        drain(0, -1, 0, cap, "t3_s0", lg);
        check_eq("t3_ovr1", overrun_o, 1);
        wait_v(4, "t3_next", cap);
        drain(0, -1, 1, cap, "t3_s1", lg);
        stop_pulse(cap);
        drain(0, -1, 2, cap, "t3_fin", lg);
        check_eq("t3_idle", busy_o, 0);
        check_eq("t3_ovr_sticky", overrun_o, 1);

        // Interval 0: no periodic snapshots, only the final one
        start_run(0, "t4");
        check_eq("t4_ovr_clr", overrun_o, 0);
        vcnt = 0;
        repeat (500) begin
            tick();
            if (v_o) vcnt++;
        end
        check_eq("t4_no_periodic", vcnt, 0);
        check_eq("t4_en_before", en_o, 1);
        stop_pulse(cap);
        check_eq("t4_en_after", en_o, 0);
        drain(0, -1, 0, cap, "t4_fin", lg);
        check_eq("t4_idle", busy_o, 0);

        // Stop at idx 10 mid-drain: finish snapshot, then a final one
        start_run(100, "t5");
        wait_v(100, "t5_first", cap);
        drain(0, 10, 0, cap, "t5_s0", lg);
        check_eq("t5_en_frozen", en_o, 0);
        check_eq("t5_final_v", v_o, 1);
        drain(0, -1, 1, lg, "t5_fin", lg);
        check_eq("t5_idle", busy_o, 0);
        check_eq("t5_seq2", seq_o, 2);

        // Asynchronous reset at idx 30 of a drain, with overrun already set
        start_run(20, "t6");
        wait_v(20, "t6_first", cap);
        repeat (30) tick();
        check_eq("t6_idx30", idx_o, 30);
        check_eq("t6_ovr_pre", overrun_o, 1);
        #2;
        aresetn_i = 1'b0;
        #1;
        check_eq("t6_rst_v", v_o, 0);
        check_eq("t6_rst_en", en_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_ovr", overrun_o, 0);
        check_eq("t6_rst_idx", idx_o, 0);
        @(negedge clk_i);
        aresetn_i = 1'b1;
        start_run(100, "t6r");
        check_eq("t6r_ovr", overrun_o, 0);
        wait_v(100, "t6r_first", cap);
        drain(0, -1, 0, cap, "t6r_s0", lg);
        stop_pulse(cap);
        drain(0, -1, 1, cap, "t6r_fin", lg);
        check_eq("t6r_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_profiler_sampler.md
Name: bp_profiler_sampler

Overview:
- Run-control and readout sequencer for the core stall/event counter bank (56 × width_p counters).
- Drives the bank's enable and clear inputs. Periodically snapshots all counters into a shadow register.
- Streams the snapshot one word per handshake toward the host-side FIFO / AXI-lite shell.
- Lets the host take cumulative time-series profiles without stopping the core.

Parameters:
- width_p, 32, width of each counter word and of data_o.
- els_p, 56, number of counters in the bank.
- interval_width_p, 32, width of the sample-interval programming input.
- seq_width_p, 16, width of the snapshot sequence number.

Ports:
- clk_i  in  1  clock.
- aresetn_i  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse; begins a profiling run.
- stop_i  in  1  single-cycle pulse; ends the run after a final snapshot.
- interval_i  in  interval_width_p  cycles between periodic snapshots. 0 = no periodic snapshots, final only. Sampled at start.
- counters_i  in  els_p*width_p  live counter values; word k at bits [k*width_p +: width_p].
- en_o  out  1  counter-bank enable.
- clear_o  out  1  counter-bank clear.
- v_o  out  1  stream word valid.
- ready_i  in  1  stream word ready.
- data_o  out  width_p  snapshot word.
- idx_o  out  clog2(els_p)  index of the word on data_o.
- last_o  out  1  asserted with idx_o == els_p-1.
- seq_o  out  seq_width_p  sequence number of the snapshot being streamed.
- busy_o  out  1  state != IDLE.
- overrun_o  out  1  sticky: a periodic snapshot was dropped. Cleared by start_i.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; en_o, clear_o, v_o, last_o, overrun_o = 0.
  - idx_o, seq_o, data_o, interval counter, stop_pending = 0.
  - Reset mid-stream drops v_o immediately; the partial snapshot is discarded.
- States: IDLE, CLEAR, RUN, DRAIN, FINAL.
- IDLE:
  - en_o = 0.
  - start_i → CLEAR. On that edge: latch interval_i, seq = 0, overrun_o = 0.
  - start_i and stop_i together in IDLE: stop wins, remain IDLE.
- CLEAR: exactly one cycle with clear_o = 1 and en_o = 0, then → RUN.
- RUN:
  - en_o = 1.
  - Interval counter increments each cycle. When it equals interval−1 (interval ≠ 0): capture counters_i into the shadow register, reset the interval counter to 0, → DRAIN.
  - stop_i in RUN: en_o = 0 from the next cycle, capture the shadow from the current-cycle counters_i, → FINAL.
  - If the interval expiry and stop_i coincide, take the FINAL path only, with one snapshot.
- DRAIN / FINAL:
  - v_o = 1; data_o = shadow[idx_o].
  - Each v_o & ready_i handshake increments idx_o. On the last handshake (idx_o = els_p−1), idx_o → 0 and seq increments, wrapping modulo 2^seq_width_p.
  - v_o must not drop without a handshake; data_o and idx_o are stable while v_o & ~ready_i.
  - In DRAIN, en_o stays 1 and the interval counter keeps running. Expiry during DRAIN: drop that sample, set overrun_o, restart the interval counter.
  - stop_i in DRAIN: en_o = 0 from the next cycle and stop_pending is set. At DRAIN end with stop_pending: capture a new shadow (frozen counters), → FINAL.
  - DRAIN end without stop_pending → RUN.
  - FINAL end → IDLE, stop_pending = 0.
  - stop_i in FINAL, CLEAR or IDLE is ignored. start_i outside IDLE is ignored.
- Latency:
  - Snapshot reflects counters_i at the capture edge; first v_o the following cycle.
  - A full snapshot takes ≥ els_p cycles to stream.

Test Plan:
- interval_i = 100, ready_i = 1, start pulse → clear_o high 1 cycle. First capture 100 cycles after RUN entry. Words stream idx 0..55 in 56 cycles, last_o on idx 55, seq_o = 0 then 1.
- ready_i toggling 1-of-3 cycles during DRAIN → data_o/idx_o held while stalled. Exactly 56 handshakes, values match the captured counters.
- interval_i = 20, ready_i = 1 → drain overlaps expiry. overrun_o = 1; the next snapshot arrives 20 cycles after the drop, not immediately.
- interval_i = 0, start, run 500 cycles, stop → no periodic snapshots. en_o falls the cycle after stop. One FINAL snapshot with seq_o = 0, then busy_o = 0.
- stop_i at idx_o = 10 mid-DRAIN → current snapshot completes (46 more words), a FINAL snapshot follows with seq incremented, then IDLE.
- aresetn_i pulsed low at idx_o = 30 → v_o, en_o, busy_o = 0 asynchronously. After release, start_i yields a fresh run with seq_o = 0 and overrun_o = 0.
